// File: rtl/nibble_adder_scheduler.sv
// Time-shares one external 4-bit adder slice between two requesters. Each accepted
// request is added LSB nibble first, with the carry chained through a register.
module nibble_adder_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_co,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_id;
  logic             r_last;
  logic [IW-1:0]    r_idx;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_idle;
  logic             w_run;
  logic             w_grant;
  logic             w_accept;
  logic [IW+1:0]    w_base;

  assign w_idle = (r_state == StIdle);
  assign w_run  = (r_state == StRun);
  assign w_base = {r_idx, 2'b00};

  // With both requesters valid, the one not served last wins; r_last resets to 1
  // so requester 0 goes first after reset.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else begin
      w_grant = req1_valid;
    end
  end

  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_accept   = req0_ready || req1_ready;

  assign add_a   = w_run ? r_a[w_base +: 4] : 4'h0;
  assign add_b   = w_run ? r_b[w_base +: 4] : 4'h0;
  assign add_cin = w_run ? r_carry : 1'b0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_carry;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a     <= w_grant ? req1_a : req0_a;
            r_b     <= w_grant ? req1_b : req0_b;
            r_carry <= w_grant ? req1_cin : req0_cin;
            r_id    <= w_grant;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sum[w_base +: 4] <= add_s;
          r_carry            <= add_co;
          if (r_idx == IW'(NIB - 1)) begin
            r_idx       <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= r_id;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_adder_scheduler.sv
// Bench for nibble_adder_scheduler: models the adder slice and predicts sums, ids and
// arbitration order from whole-word arithmetic and a round-robin rule.
module tb_nibble_adder_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_sum;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_co, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  nibble_adder_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_co(add_co),
    .busy(busy)
  );

  // External adder slice
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'b0, cin};
  endfunction

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Issues one request, waits for its response (rsp_ready high); ends at posedge+1 in idle.
  task automatic run_one(input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] s, output logic co,
                         output logic rid, output int run_cyc, output logic [7:0] cin_tr,
                         output bit to);
    int n;
    to = 0; run_cyc = 0; cin_tr = '0; s = '0; co = 0; rid = 0;
    rsp_ready = 1;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin to = 1; req0_valid = 0; req1_valid = 0; return; end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      cin_tr = {cin_tr[6:0], add_cin}; run_cyc++;
      @(negedge clk); n++;
    end
    if (n >= 50) begin to = 1; return; end
    s = rsp_sum; co = rsp_cout; rid = rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_cin = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin, busy,
         req0_ready, req1_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b id=%b sum=%h cout=%b a=%h b=%h cin=%b busy=%b want all 0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin, busy);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co, rid; int rc; logic [7:0] ct; bit to;
    run_one(0, 16'h1234, 16'h4321, 0, s, co, rid, rc, ct, to);
    n_cmp++;
    if (to || {s, co, rid} !== {16'h5555, 1'b0, 1'b0} || rc != 4) begin
      n_fail++;
      $display("FAIL basic_add: got sum=%h cout=%b id=%b run=%0d to=%0d want 5555 0 0 4",
               s, co, rid, rc, to);
    end
    run_one(1, 16'hFFFF, 16'h0000, 1, s, co, rid, rc, ct, to);
    n_cmp++;
    if (to || {s, co, rid} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL carry_chain: got sum=%h cout=%b id=%b to=%0d want 0000 1 1", s, co, rid, to);
    end
    n_cmp++;
    if (ct[3:0] !== 4'b1111 || rc != 4) begin
      n_fail++; $display("FAIL carry_seq: got cin=%b run=%0d want 1111 4", ct[3:0], rc);
    end
  endtask

  task automatic test_arbitration();
    logic [16:0] e; bit eid; int n;
    do_reset();
    req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
    req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      eid = k[0];
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 50) begin @(negedge clk); n++; end
      n_cmp++;
      if (n >= 50 || (req0_ready && req1_ready) || req1_ready !== eid) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got r0=%b r1=%b want grant %0d", k, req0_ready,
                 req1_ready, eid);
      end
      e = eid ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
      @(posedge clk); #1;
      if (eid) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
      else     begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      n_cmp++;
      if (n >= 50 || {rsp_cout, rsp_sum, rsp_id} !== {e, eid}) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got cout=%b sum=%h id=%b want %b %h %b", k, rsp_cout,
                 rsp_sum, rsp_id, e[16], e[15:0], eid);
      end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [16:0] e, e1; int n;
    req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
    e = ref_add(req0_a, req0_b, req0_cin);
    rsp_ready = 0; req0_valid = 1;
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom); req1_valid = 1;
    e1 = ref_add(req1_a, req1_b, req1_cin);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== e || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0 || {add_a, add_b, add_cin} !== 9'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b sum=%h cout=%b r0=%b r1=%b add=%h/%h/%b busy=%b want 1 %h %b 0 0 0 1",
                 i, rsp_valid, rsp_sum, rsp_cout, req0_ready, req1_ready, add_a, add_b,
                 add_cin, busy, e[15:0], e[16]);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resume: got r1=%b valid=%b want 1 0", req1_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 50 || {rsp_cout, rsp_sum, rsp_id} !== {e1, 1'b1}) begin
      n_fail++;
      $display("FAIL resume_rsp: got %b %h %b want %b %h 1", rsp_cout, rsp_sum, rsp_id,
               e1[16], e1[15:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, rid; int rc; logic [7:0] ct; bit to; int n; bit seen;
    req0_a = 16'hABCD; req0_b = 16'h1357; req0_cin = 1; req0_valid = 1;
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 0; #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin, busy,
         req0_ready, req1_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b sum=%h cout=%b add=%h/%h/%b busy=%b want all 0",
               rsp_valid, rsp_sum, rsp_cout, add_a, add_b, add_cin, busy);
    end
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid || busy) seen = 1; end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL ghost_rsp: got activity=1 want 0"); end
    @(posedge clk); #1;
    run_one(1, 16'h00FF, 16'h0001, 0, s, co, rid, rc, ct, to);
    n_cmp++;
    if (to || {s, co, rid} !== {16'h0100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_add: got sum=%h cout=%b id=%b want 0100 0 1", s, co, rid);
    end
  endtask

  task automatic test_back_to_back();
    int last_cyc; int pulses;
    req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 0;
    rsp_ready = 1; req1_valid = 1;
    last_cyc = -1; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req1_ready) begin
        if (last_cyc >= 0) begin
          n_cmp++;
          if (c - last_cyc != 6) begin
            n_fail++; $display("FAIL spacing: got %0d want 6", c - last_cyc);
          end
        end
        last_cyc = c; pulses++;
      end
    end
    n_cmp++;
    if (pulses < 6) begin n_fail++; $display("FAIL pulse_count: got %0d want >=6", pulses); end
    @(posedge clk); #1;
    req1_valid = 0;
    for (int c = 0; c < 20 && busy; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [16:0] e; logic [1:0] v; bit eg, last; int n, k;
    do_reset();
    last = 1;
    for (int it = 0; it < 40; it++) begin
      v = 2'($urandom_range(1, 3));
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      req0_valid = v[0]; req1_valid = v[1];
      eg = (v == 2'b11) ? ~last : v[1];
      e = eg ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
      @(negedge clk);
      n_cmp++;
      if (req0_ready !== (v[0] && !eg) || req1_ready !== (v[1] && eg)) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: got r0=%b r1=%b want %b %b", it, req0_ready,
                 req1_ready, v[0] && !eg, v[1] && eg);
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      k = $urandom_range(0, 3);
      repeat (k) @(negedge clk);
      n_cmp++;
      if (n >= 50 || rsp_valid !== 1'b1 || {rsp_cout, rsp_sum, rsp_id} !== {e, eg}) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: got v=%b %b %h %b want %b %h %b", it, rsp_valid,
                 rsp_cout, rsp_sum, rsp_id, e[16], e[15:0], eg);
      end
      @(posedge clk); #1;
      rsp_ready = 1;
      @(posedge clk); #1;
      last = eg;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
